// File: rtl/fb_bank_scheduler.sv
// Double-buffer bank scheduler between the RGB-capture writer and the framebuffer reader.
// The shared frame RAM is split into two banks: the writer fills the back bank while
// the reader streams from the front bank. Banks swap only after a complete frame has
// been captured, and (once streaming) only on a position_sync boundary.
module fb_bank_scheduler #(
  parameter int unsigned BANK_ADDR_W = 15,
  parameter int unsigned RAM_ADDR_W  = 32,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned FRAME_WORDS = 24576
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_frame_start,
  input  logic                  wr_en,
  input  logic [RAM_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [RAM_ADDR_W-1:0] rd_addr,
  input  logic                  position_sync,
  output logic                  ram_w_enable,
  output logic [RAM_ADDR_W-1:0] ram_w_addr,
  output logic [DATA_W-1:0]     ram_w_data,
  output logic [RAM_ADDR_W-1:0] ram_r_addr,
  output logic                  write_bank,
  output logic                  read_bank,
  output logic                  stream_ready,
  output logic                  bank_swap,
  output logic                  write_dropped
);

  // Count must be able to hold FRAME_WORDS itself on the completing write.
  localparam int unsigned CNT_W = $clog2(FRAME_WORDS + 1);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_WORDS);
  // Zero padding above {bank, local} in the physical RAM address.
  localparam int unsigned PAD_W = RAM_ADDR_W - BANK_ADDR_W - 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StDone = 2'd2
  } wr_state_e;

  wr_state_e        state;
  logic [CNT_W-1:0] count;
  logic             start_pending;

  logic [BANK_ADDR_W-1:0] wr_local;
  logic [BANK_ADDR_W-1:0] rd_local;
  logic [31:0]            wr_local_ext;
  logic                   start_eff;
  logic                   fill_eff;
  logic [CNT_W-1:0]       count_base;
  logic [CNT_W-1:0]       count_inc;
  logic                   in_range;
  logic                   accept;
  logic                   complete;
  logic                   swap;
  logic                   pend_eff;

  // Upper address bits are ignored by design; gathered here so they are visibly unused.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr_addr[RAM_ADDR_W-1:BANK_ADDR_W], rd_addr[RAM_ADDR_W-1:BANK_ADDR_W]};

  assign wr_local     = wr_addr[BANK_ADDR_W-1:0];
  assign rd_local     = rd_addr[BANK_ADDR_W-1:0];
  assign wr_local_ext = 32'(wr_local);

  // Decode the effective writer state: a start pulse outside StDone takes effect
  // before any write in the same cycle, so that word becomes the frame's first.
  always_comb begin
    start_eff  = wr_frame_start && (state != StDone);
    fill_eff   = start_eff || (state == StFill);
    count_base = start_eff ? '0 : count;
    count_inc  = count_base + 1'b1;
    in_range   = (wr_local_ext < FRAME_WORDS);
    accept     = wr_en && fill_eff && in_range;
    complete   = accept && (count_inc == FRAME_CNT);
    // First frame swaps immediately; afterwards wait for the rotation reference.
    swap       = (state == StDone) && (!stream_ready || position_sync);
    // A start arriving on the swap cycle itself still counts as pending.
    pend_eff   = start_pending || wr_frame_start;
  end

  // Writer FSM, bank ownership and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= StIdle;
      count         <= '0;
      start_pending <= 1'b0;
      write_bank    <= 1'b0;
      read_bank     <= 1'b1;
      stream_ready  <= 1'b0;
      bank_swap     <= 1'b0;
      write_dropped <= 1'b0;
      ram_w_enable  <= 1'b0;
      ram_w_addr    <= '0;
      ram_w_data    <= '0;
      ram_r_addr    <= '0;
    end else begin
      bank_swap     <= swap;
      write_dropped <= wr_en && !accept;
      ram_w_enable  <= accept;
      // Address uses the back bank as registered, never the post-swap value.
      if (accept) begin
        ram_w_addr <= {{PAD_W{1'b0}}, write_bank, wr_local};
        ram_w_data <= wr_data;
      end
      ram_r_addr <= {{PAD_W{1'b0}}, read_bank, rd_local};

      case (state)
        StIdle, StFill: begin
          if (fill_eff) begin
            if (complete) begin
              state <= StDone;
              count <= count_inc;
            end else begin
              state <= StFill;
              count <= accept ? count_inc : count_base;
            end
          end
        end
        StDone: begin
          if (wr_frame_start) begin
            start_pending <= 1'b1;
          end
          if (swap) begin
            write_bank    <= ~write_bank;
            read_bank     <= ~read_bank;
            stream_ready  <= 1'b1;
            count         <= '0;
            start_pending <= 1'b0;
            state         <= pend_eff ? StFill : StIdle;
          end
        end
        default: begin
          state <= StIdle;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_bank_scheduler.sv
// Self-checking bench for fb_bank_scheduler with a 4-word frame.
// Every driven cycle pushes the expected write-port response to a scoreboard queue;
// it is popped and compared one cycle later when the registered outputs appear.
module tb_fb_bank_scheduler;

  localparam int unsigned BANK_ADDR_W = 15;
  localparam int unsigned RAM_ADDR_W  = 32;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned FRAME_WORDS = 4;

  logic                  clk;
  logic                  rst;
  logic                  wr_frame_start;
  logic                  wr_en;
  logic [RAM_ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [RAM_ADDR_W-1:0] rd_addr;
  logic                  position_sync;
  logic                  ram_w_enable;
  logic [RAM_ADDR_W-1:0] ram_w_addr;
  logic [DATA_W-1:0]     ram_w_data;
  logic [RAM_ADDR_W-1:0] ram_r_addr;
  logic                  write_bank;
  logic                  read_bank;
  logic                  stream_ready;
  logic                  bank_swap;
  logic                  write_dropped;

  fb_bank_scheduler #(
    .BANK_ADDR_W(BANK_ADDR_W),
    .RAM_ADDR_W (RAM_ADDR_W),
    .DATA_W     (DATA_W),
    .FRAME_WORDS(FRAME_WORDS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_frame_start(wr_frame_start),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_addr       (rd_addr),
    .position_sync (position_sync),
    .ram_w_enable  (ram_w_enable),
    .ram_w_addr    (ram_w_addr),
    .ram_w_data    (ram_w_data),
    .ram_r_addr    (ram_r_addr),
    .write_bank    (write_bank),
    .read_bank     (read_bank),
    .stream_ready  (stream_ready),
    .bank_swap     (bank_swap),
    .write_dropped (write_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic                  en;
    logic [RAM_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
    logic                  drop;
  } wexp_t;

  wexp_t sb[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, push the expected write-port result, then compare it
  // against the registered outputs just after the clock edge.
  task automatic drive(input logic st, input logic en, input logic [31:0] a,
                       input logic [15:0] d, input logic ps, input logic exp_acc,
                       input logic bank);
    wexp_t e;
    wr_frame_start = st;
    wr_en          = en;
    wr_addr        = a;
    wr_data        = d;
    position_sync  = ps;
    e.en   = exp_acc;
    e.addr = {16'h0, bank, a[14:0]};
    e.data = d;
    e.drop = en && !exp_acc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    wr_frame_start = 1'b0;
    wr_en          = 1'b0;
    position_sync  = 1'b0;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk("w_enable", 64'(ram_w_enable), 64'(e.en));
      chk("w_dropped", 64'(write_dropped), 64'(e.drop));
      if (e.en) begin
        chk("w_addr", 64'(ram_w_addr), 64'(e.addr));
        chk("w_data", 64'(ram_w_data), 64'(e.data));
      end
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic banks(input string tag, input logic wb, input logic sw, input logic sr);
    chk({tag, "_swap"}, 64'(bank_swap), 64'(sw));
    chk({tag, "_wbank"}, 64'(write_bank), 64'(wb));
    chk({tag, "_rbank"}, 64'(read_bank), 64'(!wb));
    chk({tag, "_ready"}, 64'(stream_ready), 64'(sr));
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_wbank"}, 64'(write_bank), 64'd0);
    chk({tag, "_rbank"}, 64'(read_bank), 64'd1);
    chk({tag, "_ready"}, 64'(stream_ready), 64'd0);
    chk({tag, "_swap"}, 64'(bank_swap), 64'd0);
    chk({tag, "_drop"}, 64'(write_dropped), 64'd0);
    chk({tag, "_wen"}, 64'(ram_w_enable), 64'd0);
    chk({tag, "_waddr"}, 64'(ram_w_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(ram_w_data), 64'd0);
    chk({tag, "_raddr"}, 64'(ram_r_addr), 64'd0);
  endtask

  initial begin
    rst            = 1'b1;
    wr_frame_start = 1'b0;
    wr_en          = 1'b0;
    wr_addr        = '0;
    wr_data        = '0;
    rd_addr        = '0;
    position_sync  = 1'b0;
    @(posedge clk);
    #1;
    reset_vals("rst");
    rst = 1'b0;

    // Frame A: first frame, swap without position_sync one cycle after completion.
    drive(1'b1, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 32'(i), 16'hA0 + 16'(i), 1'b0, 1'b1, 1'b0);
    end
    banks("a_done", 1'b0, 1'b0, 1'b0);
    idle();
    banks("a_swap", 1'b1, 1'b1, 1'b1);
    idle();
    chk("a_swap_pulse", 64'(bank_swap), 64'd0);

    // Frame B: start and first word in the same cycle, then wait for position_sync.
    drive(1'b1, 1'b1, 32'd0, 16'hB0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i < 4; i++) begin
      drive(1'b0, 1'b1, 32'(i), 16'hB0 + 16'(i), 1'b0, 1'b1, 1'b1);
    end
    for (int i = 0; i < 50; i++) begin
      if (i == 10 || i == 20) drive(1'b0, 1'b1, 32'd1, 16'hBE, 1'b0, 1'b0, 1'b1);
      else idle();
      chk("b_wait_swap", 64'(bank_swap), 64'd0);
    end
    rd_addr = 32'd2;
    drive(1'b0, 1'b0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0);
    banks("b_swap", 1'b0, 1'b1, 1'b1);
    chk("b_raddr_old", 64'(ram_r_addr), 64'h0002);
    idle();
    chk("b_raddr_new", 64'(ram_r_addr), 64'h8002);

    // Frame C: drop in idle, restart after 2 words, out-of-range drop,
    // completion coinciding with position_sync must not swap.
    drive(1'b0, 1'b1, 32'd1, 16'hC9, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 32'd0, 16'hC0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 32'd1, 16'hC1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 32'd4, 16'hC4, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 32'd7, 16'hC7, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'(i), 16'hD0 + 16'(i), 1'b0, 1'b1, 1'b0);
    end
    banks("c_restart", 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 32'd3, 16'hD3, 1'b1, 1'b1, 1'b0);
    chk("c_sync_same", 64'(bank_swap), 64'd0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("c_no_swap", 64'(bank_swap), 64'd0);
    end
    drive(1'b0, 1'b0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0);
    banks("c_swap", 1'b1, 1'b1, 1'b1);

    // Frame D: start pulse while done leaves the FSM directly in fill after the swap.
    drive(1'b1, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 32'(i), 16'hE0 + 16'(i), 1'b0, 1'b1, 1'b1);
    end
    drive(1'b1, 1'b1, 32'd0, 16'hEF, 1'b0, 1'b0, 1'b1);
    chk("d_no_swap", 64'(bank_swap), 64'd0);
    drive(1'b0, 1'b0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0);
    banks("d_swap", 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 32'(i), 16'hF0 + 16'(i), 1'b0, 1'b1, 1'b0);
    end
    drive(1'b0, 1'b0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0);
    banks("d_swap2", 1'b1, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a frame.
    drive(1'b1, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 32'd0, 16'h55, 1'b0, 1'b1, 1'b1);
    wr_en   = 1'b1;
    wr_addr = 32'd1;
    wr_data = 16'h66;
    #2;
    rst = 1'b1;
    #1;
    reset_vals("mid_rst");
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    reset_vals("held_rst");
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_bank_scheduler.md
Name: fb_bank_scheduler

Overview:
Double-buffer scheduler between the RGB-capture writer and the framebuffer reader, both sharing the single dual-port frame RAM. Splits the RAM into two banks and steers writer addresses into the back bank and reader addresses into the front bank. Swaps banks only when a complete frame has been captured and the rotation reaches a position_sync boundary. Drives stream_ready toward the framebuffer.

Parameters:
BANK_ADDR_W, 15, local (per-bank) address width; physical address = {bank, local}
RAM_ADDR_W, 32, width of RAM address ports; upper bits above BANK_ADDR_W+1 driven 0
DATA_W, 16, RAM word width
FRAME_WORDS, 24576, accepted writes that make a complete frame; must be <= 2**BANK_ADDR_W

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
wr_frame_start  in  1  one-cycle pulse from writer: new frame begins
wr_en  in  1  writer word valid
wr_addr  in  RAM_ADDR_W  writer local address; only [BANK_ADDR_W-1:0] used
wr_data  in  DATA_W  writer data
rd_addr  in  RAM_ADDR_W  reader local address; only [BANK_ADDR_W-1:0] used
position_sync  in  1  one-cycle pulse at rotation reference
ram_w_enable  out  1  RAM write enable
ram_w_addr  out  RAM_ADDR_W  RAM physical write address
ram_w_data  out  DATA_W  RAM write data
ram_r_addr  out  RAM_ADDR_W  RAM physical read address
write_bank  out  1  current back bank
read_bank  out  1  current front bank, always ~write_bank
stream_ready  out  1  at least one complete frame is in the front bank; sticky until reset
bank_swap  out  1  one-cycle pulse on the cycle the banks swap
write_dropped  out  1  one-cycle pulse when wr_en was asserted but the word was discarded

Behaviour:
- Reset values: write_bank=0, read_bank=1, stream_ready=0, bank_swap=0, write_dropped=0, ram_w_enable=0, ram_w_addr=0, ram_w_data=0, ram_r_addr=0, state W_IDLE, count=0, start_pending=0.
- Writer FSM has three states:
  - W_IDLE: wr_frame_start -> W_FILL with count=0.
  - W_FILL: each accepted write increments count. The write that makes count==FRAME_WORDS moves the FSM to W_DONE on the same edge.
  - W_DONE: holds until swap.
- A write is accepted iff wr_en=1, the effective state is W_FILL, and wr_addr local < FRAME_WORDS. Any other wr_en=1 gives a write_dropped pulse on the next cycle with no RAM write.
- wr_frame_start and wr_en in the same cycle (from W_IDLE or W_FILL): the start takes effect first, the word is accepted as the first word of the new frame, and count becomes 1.
- wr_frame_start in W_FILL: aborts the partial frame, count=0, bank unchanged. The torn data is overwritten.
- wr_frame_start in W_DONE: sets start_pending. All writes are dropped.
- Swap conditions, evaluated in W_DONE:
  - If stream_ready=0, swap on the first W_DONE cycle.
  - If stream_ready=1, swap on the first cycle with position_sync=1.
- On swap: write_bank<=~write_bank, read_bank<=~read_bank, stream_ready<=1, bank_swap=1 for one cycle, count=0. The FSM goes to W_FILL if start_pending (which is cleared), else W_IDLE.
- position_sync in the same cycle as the completing write: no swap, because W_DONE is not yet registered. Swap waits for the next position_sync. position_sync outside W_DONE is ignored.
- Write path is registered, latency 1:
  - ram_w_enable = accepted.
  - ram_w_addr = {0, write_bank, wr_addr[BANK_ADDR_W-1:0]}, using write_bank before any swap on that edge.
  - ram_w_data = wr_data.
- Read path is registered, latency 1: ram_r_addr = {0, read_bank, rd_addr[BANK_ADDR_W-1:0]}. The first address using the new bank appears the cycle after bank_swap.
- Writes are never directed to read_bank. The write address is computed from the registered write_bank.
- count width is clog2(FRAME_WORDS+1). It saturates by construction, because W_DONE blocks further increments.
- rst mid-frame: immediate return to reset values. stream_ready drops to 0 and the reader must stop.

Test Plan:
- FRAME_WORDS=4, reset, pulse wr_frame_start, write addr 0..3 data A0..A3 -> ram_w_addr bank0 0..3 one cycle later; bank_swap pulse 1 cycle after the last write without position_sync; write_bank=1, read_bank=0, stream_ready=1.
- Second frame B0..B3 completes, no position_sync for 50 cycles -> no swap, writes after completion give write_dropped; position_sync pulse -> bank_swap next edge, read_bank=1, ram_r_addr for rd_addr=2 equals {1,2}=0x8002.
- Completing write and position_sync in the same cycle -> no swap; swap only on the following position_sync.
- wr_frame_start after 2 words in W_FILL -> count restarts; 4 more writes are needed to complete, and bank is unchanged.
- wr_frame_start during W_DONE, then position_sync -> after swap the FSM is directly in W_FILL; the next 4 writes are accepted into the new back bank without another start.
- Writes with local addr >= FRAME_WORDS, or while in W_IDLE -> write_dropped pulse, ram_w_enable=0; assert rst mid-frame -> all outputs return to reset values asynchronously.
